// File: rtl/writeback_pkg.sv
// Shared pipeline definitions used by the writeback stage: the writeback
// FSM state encoding, the default trap vector and small counter helpers.
package writeback_pkg;

  // Writeback FSM: RUN accepts results, FLUSH discards them while the
  // front of the pipeline is being killed after a redirect.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

  // Default PC loaded on any exception.
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  // Width of the flush down-counter; it supports holds of 1..7 cycles.
  localparam int FLUSH_CNT_W = 3;

  // Saturating 16-bit increment used by the trap counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // Counter value loaded when entering FLUSH. The counter counts down to
  // zero, so a hold of N cycles loads N-1.
  function automatic logic [FLUSH_CNT_W-1:0] flush_load(input int cycles);
    return FLUSH_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/writeback.sv
// Writeback stage: retires execute-stage results into the register file,
// turns jumps and exceptions into a one-cycle fetch redirect followed by a
// pipeline flush of FLUSH_CYCLES cycles, and keeps trap/retire statistics.
//
// Handshake: ex_stall is permanently 0, so every cycle with ex_valid=1 is a
// transfer. The stage never backpressures; results offered while in FLUSH
// are accepted and silently dropped.
module writeback
  import writeback_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  // Result handshake from execute
  input  logic        ex_valid,
  output logic        ex_stall,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_rd_val,
  input  logic [31:0] ex_inst_pc,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_pc,
  input  logic        ex_exception_valid,
  input  logic [5:0]  ex_exception_num,
  // Register-file write port
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  // Pipeline kill and fetch redirect
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  // Trap state
  output logic [31:0] mepc,
  output logic [5:0]  mcause,
  output logic [15:0] trap_count,
  // Statistics
  output logic [63:0] retire_count,
  // FSM state, exposed for observation
  output logic        dbg_state
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = flush_load(FLUSH_CYCLES);

  wb_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   flush_q, flush_d;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic                   rf_we_q, rf_we_d;
  logic [4:0]             rf_waddr_q, rf_waddr_d;
  logic [31:0]            rf_wdata_q, rf_wdata_d;
  logic [31:0]            mepc_q, mepc_d;
  logic [5:0]             mcause_q, mcause_d;
  logic [15:0]            trap_count_q, trap_count_d;
  logic [63:0]            retire_count_q, retire_count_d;

  logic transfer;
  logic take_trap;
  logic take_retire;
  logic take_jump;

  // Decode what the current transfer does; only meaningful in RUN.
  always_comb begin
    transfer    = ex_valid && (state_q == RUN);
    take_trap   = transfer && ex_exception_valid;
    take_retire = transfer && !ex_exception_valid;
    take_jump   = take_retire && ex_jump;
  end

  // Next-state and next-output logic for the writeback FSM.
  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    flush_d          = flush_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    rf_we_d          = 1'b0;
    rf_waddr_d       = rf_waddr_q;
    rf_wdata_d       = rf_wdata_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    trap_count_d     = trap_count_q;
    retire_count_d   = retire_count_q;

    case (state_q)
      RUN: begin
        if (take_trap) begin
          // Exception: no register write, capture cause and PC, and
          // redirect to the trap vector. Any jump request is ignored.
          mepc_d           = ex_inst_pc;
          mcause_d         = ex_exception_num;
          trap_count_d     = sat_inc16(trap_count_q);
          redirect_valid_d = 1'b1;
          redirect_pc_d    = TRAP_VECTOR;
          state_d          = FLUSH;
          fcnt_d           = FLUSH_LOAD;
          flush_d          = 1'b1;
        end else if (take_retire) begin
          // Normal retire. x0 is never written, but the address/data
          // registers still follow the retiring instruction.
          rf_we_d        = (ex_rd != 5'd0);
          rf_waddr_d     = ex_rd;
          rf_wdata_d     = ex_rd_val;
          retire_count_d = retire_count_q + 64'd1;
          if (take_jump) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = ex_jump_pc;
            state_d          = FLUSH;
            fcnt_d           = FLUSH_LOAD;
            flush_d          = 1'b1;
          end
        end
      end

      FLUSH: begin
        // flush was raised on entry; it stays up while the counter runs
        // down and drops on the cycle the FSM returns to RUN.
        if (fcnt_q == '0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end

      default: begin
        state_d = RUN;
        fcnt_d  = '0;
        flush_d = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      fcnt_q           <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= 5'd0;
      rf_wdata_q       <= 32'd0;
      mepc_q           <= 32'd0;
      mcause_q         <= 6'd0;
      trap_count_q     <= 16'd0;
      retire_count_q   <= 64'd0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      rf_we_q          <= rf_we_d;
      rf_waddr_q       <= rf_waddr_d;
      rf_wdata_q       <= rf_wdata_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      trap_count_q     <= trap_count_d;
      retire_count_q   <= retire_count_d;
    end
  end

  // The stage never stalls execute.
  assign ex_stall       = 1'b0;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign trap_count     = trap_count_q;
  assign retire_count   = retire_count_q;
  assign dbg_state      = state_q;

endmodule
